// File: rtl/apb_efuse_loader.sv
// apb_efuse_loader: APB master that copies the first NUM_WORDS fuse words into a shadow bank on start_i.
// Build macro EFUSE_LOADER_CFG_EN adds a CFG register write ahead of opening the read window.
module apb_efuse_loader #(
  parameter int          APB_ADDR_WIDTH = 12,
  parameter int          NUM_WORDS      = 8,
  parameter int          TIMEOUT        = 4096,
  parameter logic [31:0] CFG_VALUE      = 32'h0CB2_0C82
) (
  input  logic                        PCLK,
  input  logic                        PRESET,
  input  logic                        start_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        error_o,
  output logic                        word_valid_o,
  output logic [6:0]                  word_idx_o,
  output logic [31:0]                 word_data_o,
  output logic [32*NUM_WORDS-1:0]     shadow_o,
  output logic [APB_ADDR_WIDTH-1:0]   PADDR,
  output logic [31:0]                 PWDATA,
  output logic                        PWRITE,
  output logic                        PSEL,
  output logic                        PENABLE,
  input  logic [31:0]                 PRDATA,
  input  logic                        PREADY,
  input  logic                        PSLVERR
);

  localparam int             TMO_W    = $clog2(TIMEOUT) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [6:0]     LAST_IDX = 7'(NUM_WORDS - 1);
  localparam logic [31:0]    CMD_OPEN  = 32'h0000_0001;
  localparam logic [31:0]    CMD_CLOSE = 32'h0000_0004;

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef EFUSE_LOADER_CFG_EN
    S_CFG,
`endif
    S_OPEN,
    S_READ,
    S_CLOSE,
    S_DONE,
    S_ERR
  } state_t;

  // PH_GAP is the mandatory PSEL-low cycle separating consecutive transfers.
  typedef enum logic [1:0] {
    PH_GAP,
    PH_SETUP,
    PH_ACCESS
  } phase_t;

  state_t                 state_q, state_d;
  phase_t                 phase_q, phase_d;
  logic [6:0]             idx_q, idx_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   capture;
  logic                   word_valid_q;
  logic [6:0]             word_idx_q;
  logic [31:0]            word_data_q;
  logic [32*NUM_WORDS-1:0] shadow_q;
  logic                   in_xfer;

`ifndef EFUSE_LOADER_CFG_EN
  logic unused_cfg_value;
  assign unused_cfg_value = ^CFG_VALUE;
`endif

  assign in_xfer = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q      <= S_IDLE;
      phase_q      <= PH_GAP;
      idx_q        <= '0;
      tmo_q        <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      word_valid_q <= 1'b0;
      word_idx_q   <= '0;
      word_data_q  <= '0;
      shadow_q     <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      idx_q        <= idx_d;
      tmo_q        <= tmo_d;
      done_q       <= done_d;
      err_q        <= err_d;
      word_valid_q <= capture;
      if (capture) begin
        word_idx_q  <= idx_q;
        word_data_q <= PRDATA;
      end
      for (int w = 0; w < NUM_WORDS; w++) begin
        if (capture && (idx_q == 7'(w))) begin
          shadow_q[32*w +: 32] <= PRDATA;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    done_d  = done_q;
    err_d   = err_q;
    capture = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          idx_d   = '0;
          phase_d = PH_SETUP;
`ifdef EFUSE_LOADER_CFG_EN
          state_d = S_CFG;
`else
          state_d = S_OPEN;
`endif
        end
      end
      S_DONE, S_ERR: begin
        state_d = S_IDLE;
        phase_d = PH_GAP;
      end
      default: begin
        case (phase_q)
          PH_GAP: begin
            phase_d = PH_SETUP;
          end
          PH_SETUP: begin
            phase_d = PH_ACCESS;
            tmo_d   = '0;
          end
          default: begin
            // A transfer ends on PREADY, or is abandoned once the wait budget runs out.
            if (PREADY) begin
              phase_d = PH_GAP;
              if (PSLVERR) begin
                state_d = S_ERR;
                err_d   = 1'b1;
              end else begin
                case (state_q)
`ifdef EFUSE_LOADER_CFG_EN
                  S_CFG:   state_d = S_OPEN;
`endif
                  S_OPEN: begin
                    state_d = S_READ;
                    idx_d   = '0;
                  end
                  S_READ: begin
                    capture = 1'b1;
                    if (idx_q == LAST_IDX) begin
                      state_d = S_CLOSE;
                    end else begin
                      idx_d = idx_q + 7'd1;
                    end
                  end
                  default: begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                  end
                endcase
              end
            end else if (tmo_q == TMO_LAST) begin
              phase_d = PH_GAP;
              state_d = S_ERR;
              err_d   = 1'b1;
            end else begin
              tmo_d = tmo_q + 1'b1;
            end
          end
        endcase
      end
    endcase
  end

  // Address, data and direction depend only on the state, so they hold across SETUP and ACCESS.
  always_comb begin
    PADDR  = '0;
    PWDATA = '0;
    PWRITE = 1'b0;
    case (state_q)
`ifdef EFUSE_LOADER_CFG_EN
      S_CFG: begin
        PADDR  = APB_ADDR_WIDTH'(32'h004);
        PWDATA = CFG_VALUE;
        PWRITE = 1'b1;
      end
`endif
      S_OPEN: begin
        PADDR  = '0;
        PWDATA = CMD_OPEN;
        PWRITE = 1'b1;
      end
      S_READ: begin
        PADDR  = APB_ADDR_WIDTH'(32'h200 + {23'd0, idx_q, 2'b00});
      end
      S_CLOSE: begin
        PADDR  = '0;
        PWDATA = CMD_CLOSE;
        PWRITE = 1'b1;
      end
      default: ;
    endcase
  end

  assign PSEL         = in_xfer && (phase_q != PH_GAP);
  assign PENABLE      = in_xfer && (phase_q == PH_ACCESS);
  assign busy_o       = in_xfer;
  assign done_o       = done_q;
  assign error_o      = err_q;
  assign word_valid_o = word_valid_q;
  assign word_idx_o   = word_idx_q;
  assign word_data_o  = word_data_q;
  assign shadow_o     = shadow_q;

endmodule

// File: tb/tb_apb_efuse_loader.sv
// tb_apb_efuse_loader: randomized scoreboard bench for apb_efuse_loader with a behavioural APB slave.
// Expected transfers and captured words come from a sequence-level model of the load procedure.
module tb_apb_efuse_loader;

  localparam int          AW   = 12;
  localparam int          NW   = 4;
  localparam int          TMO  = 16;
  localparam logic [31:0] CFGV = 32'h0CB2_0C82;

  logic            PCLK = 1'b0;
  logic            PRESET = 1'b1;
  logic            start_i = 1'b0;
  logic            busy_o, done_o, error_o, word_valid_o;
  logic [6:0]      word_idx_o;
  logic [31:0]     word_data_o;
  logic [32*NW-1:0] shadow_o;
  logic [AW-1:0]   PADDR;
  logic [31:0]     PWDATA;
  logic            PWRITE, PSEL, PENABLE;
  logic [31:0]     PRDATA = '0;
  logic            PREADY = 1'b0;
  logic            PSLVERR = 1'b0;

  always #5 PCLK = ~PCLK;

  apb_efuse_loader #(
    .APB_ADDR_WIDTH(AW),
    .NUM_WORDS(NW),
    .TIMEOUT(TMO),
    .CFG_VALUE(CFGV)
  ) dut (
    .PCLK(PCLK),
    .PRESET(PRESET),
    .start_i(start_i),
    .busy_o(busy_o),
    .done_o(done_o),
    .error_o(error_o),
    .word_valid_o(word_valid_o),
    .word_idx_o(word_idx_o),
    .word_data_o(word_data_o),
    .shadow_o(shadow_o),
    .PADDR(PADDR),
    .PWDATA(PWDATA),
    .PWRITE(PWRITE),
    .PSEL(PSEL),
    .PENABLE(PENABLE),
    .PRDATA(PRDATA),
    .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [31:0] data;
  } xfer_t;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } word_t;

  xfer_t       expXfer[$];
  word_t       expWord[$];
  logic [31:0] fuse[NW];
  logic [31:0] shadowModel[NW];
  bit          expDone, expErr;
  int          expSetups;

  int checks = 0;
  int failures = 0;

  int slaveWs = 0;
  int slaveErrIdx = -1;
  bit slaveHang = 1'b0;
  int waitCnt = 0;

  int          setupCount = 0;
  int          wordsSeen = 0;
  int          accessCycles = 0;
  bit          prevPsel = 1'b0;
  bit          pendingWord = 1'b0;
  logic [AW-1:0] setupAddr;
  logic [31:0] setupData;
  logic        setupWrite;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Sequence-level model: which transfers the loader must issue and which words it must deliver.
  task automatic buildExpect(input int errIdx, input bit hang);
    int lastRead;
    expXfer.delete();
    expWord.delete();
    expDone = 1'b0;
    expErr  = 1'b0;
`ifdef EFUSE_LOADER_CFG_EN
    expXfer.push_back('{wr: 1'b1, addr: 12'h004, data: CFGV});
`endif
    if (hang) begin
      expErr    = 1'b1;
      expSetups = expXfer.size() + 1;
      return;
    end
    expXfer.push_back('{wr: 1'b1, addr: 12'h000, data: 32'h1});
    lastRead = (errIdx >= 0) ? errIdx : NW - 1;
    for (int i = 0; i <= lastRead; i++) begin
      expXfer.push_back('{wr: 1'b0, addr: 12'(32'h200 + 4 * i), data: 32'h0});
      if (i != errIdx) begin
        expWord.push_back('{idx: i, data: fuse[i]});
        shadowModel[i] = fuse[i];
      end
    end
    if (errIdx >= 0) begin
      expErr = 1'b1;
    end else begin
      expXfer.push_back('{wr: 1'b1, addr: 12'h000, data: 32'h4});
      expDone = 1'b1;
    end
    expSetups = expXfer.size();
  endtask

  // Behavioural efuse controller slave, responding shortly after each rising edge.
  always @(posedge PCLK) begin
    #1;
    if (PSEL && PENABLE) begin
      if (slaveHang && PWRITE && PADDR == 12'h000 && PWDATA == 32'h1) begin
        PREADY = 1'b0;
      end else if (!PWRITE && waitCnt < slaveWs) begin
        PREADY = 1'b0;
        waitCnt++;
      end else begin
        PREADY  = 1'b1;
        PSLVERR = !PWRITE && slaveErrIdx >= 0 && PADDR == 12'(32'h200 + 4 * slaveErrIdx);
        if (!PWRITE && PADDR >= 12'h200 && ((PADDR - 12'h200) >> 2) < NW)
          PRDATA = fuse[(PADDR - 12'h200) >> 2];
        else
          PRDATA = $urandom;
      end
    end else begin
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
      PRDATA  = '0;
      waitCnt = 0;
    end
  end

  // Monitor: checks APB protocol, pops expected transfers and expected captured words.
  always @(negedge PCLK) begin
    xfer_t x;
    word_t w;
    if (!PRESET) begin
      if (word_valid_o || pendingWord)
        checkOutput("word_valid_timing", word_valid_o, pendingWord);
      if (word_valid_o) begin
        wordsSeen++;
        if (expWord.size() == 0) begin
          checkOutput("word_unexpected", 1, 0);
        end else begin
          w = expWord.pop_front();
          checkOutput("word_idx", word_idx_o, w.idx);
          checkOutput("word_data", word_data_o, w.data);
        end
      end
      pendingWord = 1'b0;
      if (PSEL && !PENABLE) begin
        checkOutput("psel_gap", prevPsel, 0);
        setupCount++;
        setupAddr    = PADDR;
        setupData    = PWDATA;
        setupWrite   = PWRITE;
        accessCycles = 0;
      end else if (PSEL && PENABLE) begin
        accessCycles++;
        checkOutput("access_stable", {PADDR, PWDATA, PWRITE}, {setupAddr, setupData, setupWrite});
        if (PREADY) begin
          checkOutput("access_len", accessCycles, PWRITE ? 1 : slaveWs + 1);
          if (expXfer.size() == 0) begin
            checkOutput("xfer_unexpected", {PWRITE, PADDR}, 0);
          end else begin
            x = expXfer.pop_front();
            checkOutput("xfer_dir", PWRITE, x.wr);
            checkOutput("xfer_addr", PADDR, x.addr);
            if (x.wr) checkOutput("xfer_wdata", PWDATA, x.data);
          end
          if (!PSLVERR && !PWRITE) pendingWord = 1'b1;
        end
      end
      prevPsel = PSEL;
    end else begin
      prevPsel    = 1'b0;
      pendingWord = 1'b0;
    end
  end

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_psel"}, {PSEL, PENABLE}, 0);
    checkOutput({tag, "_busy"}, busy_o, 0);
    checkOutput({tag, "_flags"}, {done_o, error_o}, 0);
    checkOutput({tag, "_wvalid"}, word_valid_o, 0);
    checkOutput({tag, "_shadow"}, (shadow_o == '0), 1);
  endtask

  task automatic applyStimulus(input int ws, input int errIdx, input bit hang, input bit restart, input bit midReset);
    int n;
    bit pulsed;
    slaveWs     = ws;
    slaveErrIdx = errIdx;
    slaveHang   = hang;
    buildExpect(errIdx, hang);
    setupCount = 0;
    wordsSeen  = 0;
    @(negedge PCLK);
    start_i = 1'b1;
    @(negedge PCLK);
    start_i = 1'b0;
    checkOutput("busy_after_start", busy_o, 1);
    checkOutput("flags_cleared", {done_o, error_o}, 0);

    if (midReset) begin
      n = 0;
      while (!(PSEL && PENABLE && PADDR == 12'h204) && n < 500) begin
        @(negedge PCLK);
        n++;
      end
      checkOutput("reach_word1_access", n < 500, 1);
      PRESET = 1'b1;
      @(negedge PCLK);
      expXfer.delete();
      expWord.delete();
      for (int i = 0; i < NW; i++) shadowModel[i] = '0;
      checkIdleOutputs("midreset");
      PRESET = 1'b0;
      return;
    end

    n = 0;
    pulsed = 1'b0;
    while (busy_o && n < 3000) begin
      @(negedge PCLK);
      n++;
      if (restart && !pulsed && wordsSeen == 1) begin
        start_i = 1'b1;
        pulsed  = 1'b1;
        @(negedge PCLK);
        start_i = 1'b0;
        n++;
      end
    end
    checkOutput("seq_finished", n < 3000, 1);
    checkOutput("end_done", done_o, expDone);
    checkOutput("end_error", error_o, expErr);
    checkOutput("end_psel", PSEL, 0);
    checkOutput("setup_count", setupCount, expSetups);
    if (hang) checkOutput("timeout_access_cycles", accessCycles, TMO);
    if (restart) checkOutput("restart_words", wordsSeen, NW);
    checkOutput("xfer_queue_left", expXfer.size(), 0);
    checkOutput("word_queue_left", expWord.size(), 0);
    for (int i = 0; i < NW; i++)
      checkOutput($sformatf("shadow_w%0d", i), shadow_o[32*i +: 32], shadowModel[i]);
    repeat (3) @(negedge PCLK);
    checkOutput("sticky_flags", {done_o, error_o, busy_o, PSEL}, {expDone, expErr, 1'b0, 1'b0});
    slaveHang   = 1'b0;
    slaveErrIdx = -1;
  endtask

  task automatic randomFuse();
    for (int i = 0; i < NW; i++) fuse[i] = $urandom;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int r;
    for (int i = 0; i < NW; i++) shadowModel[i] = '0;
    PRESET = 1'b1;
    repeat (3) @(negedge PCLK);
    checkIdleOutputs("reset");
    checkOutput("reset_paddr", PADDR, 0);
    PRESET = 1'b0;

    for (int i = 0; i < NW; i++) fuse[i] = 32'hA0 + i;
    applyStimulus(0, -1, 1'b0, 1'b0, 1'b0);

    randomFuse();
    applyStimulus(5, -1, 1'b0, 1'b0, 1'b0);

    randomFuse();
    applyStimulus($urandom_range(0, 3), 2, 1'b0, 1'b0, 1'b0);

    applyStimulus(0, -1, 1'b1, 1'b0, 1'b0);

    randomFuse();
    applyStimulus(2, -1, 1'b0, 1'b1, 1'b0);

    randomFuse();
    applyStimulus(5, -1, 1'b0, 1'b0, 1'b1);
    randomFuse();
    applyStimulus(1, -1, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      randomFuse();
      r = $urandom_range(0, 5);
      applyStimulus($urandom_range(0, 3), (r < NW) ? r : -1, 1'b0, 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_efuse_loader.md
Name: apb_efuse_loader

Overview:
- APB initiator (master) that drives the APB port of the efuse controller slave.
- After reset it reads the first NUM_WORDS fuse words into a shadow register bank, then returns the fuse array to idle.
- Sits between the SoC boot/power-on sequencer and the efuse controller, so trim and ID values are available before software runs.

Parameters:
- APB_ADDR_WIDTH, 12, width of PADDR.
- NUM_WORDS, 8, number of consecutive fuse words loaded, 1..128.
- TIMEOUT, 4096, maximum ACCESS-phase cycles per transfer before abort.
- CFG_VALUE, 32'h0CB2_0C82, word written to the CFG register when the optional feature is enabled (long=3250, medium=50, short=2, margin=0).

Ports:
- PCLK  in  1  clock.
- PRESET  in  1  reset, synchronous and active-high.
- start_i  in  1  one-cycle pulse; begins a load sequence.
- busy_o  out  1  high while a sequence runs.
- done_o  out  1  sticky, set when a sequence completes without error.
- error_o  out  1  sticky, set on PSLVERR or timeout.
- word_valid_o  out  1  one-cycle pulse when a fuse word is captured.
- word_idx_o  out  7  index of the captured word.
- word_data_o  out  32  captured word.
- shadow_o  out  32*NUM_WORDS  shadow bank; word i is at bits [32*i+31:32*i].
- PADDR  out  APB_ADDR_WIDTH  APB address.
- PWDATA  out  32  APB write data.
- PWRITE  out  1  APB direction.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error.

Behaviour:
- Reset values: all outputs 0 and shadow_o all-zero; FSM in S_IDLE.
- Reset is synchronous: PRESET asserted mid-transfer drops PSEL/PENABLE on the next edge and clears the sticky flags. No idle command is sent; the slave must be reset together with this block.
- Slave address map:
  - CMD at 0x000: write 0x1 = enter read mode, 0x4 = return to idle.
  - CFG at 0x004.
  - Fuse word i at 0x200 + 4*i.
- Every transfer is two-phase APB:
  - SETUP: one cycle, PSEL=1, PENABLE=0, address/data/PWRITE valid.
  - ACCESS: PSEL=1, PENABLE=1, held until PREADY=1.
  - PADDR, PWDATA and PWRITE stay stable across both phases.
  - PSEL deasserts for at least one cycle between transfers, so no back-to-back transfers.
- Main FSM, each transfer state having SETUP and ACCESS sub-phases:
  - S_IDLE: start_i -> S_CFG if the feature is enabled, else S_OPEN. busy_o=1 from the cycle after start_i.
  - S_CFG: write CFG_VALUE to 0x004.
  - S_OPEN: write 0x1 to 0x000.
  - S_READ: read 0x200+4*idx with idx from 0 to NUM_WORDS-1. The access completes when PREADY=1 and PSLVERR=0. In the cycle after completion:
    - word_valid_o=1;
    - word_idx_o=idx;
    - word_data_o=PRDATA sampled at completion;
    - shadow word idx updated.
    - After the last word -> S_CLOSE.
  - S_CLOSE: write 0x4 to 0x000.
  - S_DONE: busy_o=0, done_o=1 -> S_IDLE.
  - S_ERR: busy_o=0, error_o=1 -> S_IDLE.
- Error handling:
  - PSLVERR=1 with PREADY=1 on any transfer -> S_ERR. Remaining transfers are abandoned.
  - Timeout counter: 0 at ACCESS entry, incremented per ACCESS cycle. If it reaches TIMEOUT-1 without PREADY -> PSEL drops and FSM goes to S_ERR.
- start_i while busy_o=1 is ignored.
- start_i in S_IDLE clears done_o and error_o in the same edge as it launches the sequence. The shadow bank is not cleared.
- idx width is 7 bits; NUM_WORDS=128 ends at idx=127 without wrap.

Optional Feature:
- Macro: EFUSE_LOADER_CFG_EN.
- Defined: the sequence begins with an S_CFG write of CFG_VALUE to 0x004 before S_OPEN.
- Undefined: S_CFG does not exist; S_IDLE goes directly to S_OPEN and the slave's reset timing is used.
- Both builds share the same ports.

Test Plan:
- Zero-wait slave (PREADY=1 in ACCESS), NUM_WORDS=4, fuse words 0xA0..0xA3, start_i pulse -> exact transfer sequence (with CFG_EN: CFG, CMD=0x1, four reads at 0x200/0x204/0x208/0x20C, CMD=0x4); each transfer takes 2 cycles; shadow_o={0xA3,0xA2,0xA1,0xA0}; done_o=1; error_o=0.
- Slave adds 5 wait states per read -> PADDR/PWDATA/PWRITE stable through ACCESS; 4 word_valid_o pulses with idx 0..3; done_o=1.
- PSLVERR=1 on the read of word 2 -> no further PSEL; error_o=1; done_o=0; shadow words 0-1 updated, words 2-3 unchanged.
- PREADY never returned on CMD=0x1 with TIMEOUT=16 -> PSEL drops after 16 ACCESS cycles; error_o=1; busy_o=0.
- start_i pulsed again at word 1 -> ignored; single sequence completes; exactly NUM_WORDS word_valid_o pulses.
- PRESET asserted during ACCESS of word 1 -> next edge: PSEL=0, busy_o=0, shadow_o=0, flags 0; a later start_i runs a full clean sequence.
